// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock digit stages: operating modes and
// the active-low 7-segment patterns (bit order gfedcba).
package clock_pkg;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } mode_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] val);
        case (val)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/segundos_dezena_key_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a one-cycle
// pulse when an active-low press is accepted.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n_i,
    output logic press_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        // A mismatching sample extends the run; the DEBOUNCE_CYCLES-th one flips the level.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = ~stable_q;
                press_d  = stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= key_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/segundos_dezena.sv
// Tens-of-seconds digit: counts carry_in rising edges modulo MODULUS in RUN,
// steps on debounced presses in ADJUST, and drives an active-low 7-seg display.
module segundos_dezena
    import clock_pkg::*;
#(
    parameter int MODULUS         = 6,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       carry_in,
    input  logic       sw_ctl,
    input  logic       key_run_n,
    input  logic       key_set_n,
    output logic       carry_out,
    output logic [3:0] digit,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g
);
    localparam logic [3:0] LAST = 4'(MODULUS - 1);

    mode_e      mode_q, mode_d;
    logic [3:0] digit_q, digit_d;
    logic       cout_q, cout_d;
    logic       cprev_q;
    logic [6:0] seg_q;
    logic       press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_key (
        .clock   (clock),
        .reset   (reset),
        .key_n_i (key_set_n),
        .press_o (press)
    );

    always_comb begin
        if (!sw_ctl)        mode_d = ADJUST;
        else if (!key_run_n) mode_d = RUN;
        else                mode_d = CLEAR;

        digit_d = digit_q;
        cout_d  = 1'b0;
        case (mode_q)
            RUN: if (carry_in && !cprev_q) begin
                if (digit_q == LAST) begin
                    digit_d = '0;
                    cout_d  = 1'b1;
                end else begin
                    digit_d = digit_q + 1'b1;
                end
            end
            // Manual stepping wraps silently: the minutes stage must not see it.
            ADJUST: if (press) digit_d = (digit_q == LAST) ? 4'd0 : digit_q + 1'b1;
            default: digit_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q  <= CLEAR;
            digit_q <= '0;
            cout_q  <= 1'b0;
            cprev_q <= 1'b0;
            seg_q   <= SEG_0;
        end else begin
            mode_q  <= mode_d;
            digit_q <= digit_d;
            cout_q  <= cout_d;
            cprev_q <= carry_in;
            seg_q   <= seg_encode(digit_q);
        end
    end

    assign carry_out           = cout_q;
    assign digit               = digit_q;
    assign {g, f, e, d, c, b, a} = seg_q;

endmodule
